// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - scheduler state encoding, default widths and a small constant helper
package counter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_REPORT  = 3'd3,
    ST_NEXT    = 3'd4
  } sched_state_t;

  localparam int DEF_COUNTER_NUM = 4;
  localparam int DEF_SETTLE_CYC  = 4;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_WIN_W       = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/counter_mux_sched_edge.sv
// rtl/counter_mux_sched_edge.sv - rising-edge detector feeding a saturating counter with overflow flag
module counter_mux_sched_edge
  import counter_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic prev;
  logic rise;

  assign rise = din & ~prev;

  // prev tracks the input every cycle so the first counted cycle sees a real history
  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= 1'b0;
      cnt  <= '0;
      ovf  <= 1'b0;
    end else begin
      prev <= din;
      if (clr) begin
        cnt <= '0;
        ovf <= 1'b0;
      end else if (en && rise) begin
        if (cnt == CNT_MAX) begin
          ovf <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/counter_mux_sched.sv
// rtl/counter_mux_sched.sv - per-channel source a/b scheduler with settle blanking and windowed edge counts
// Defining COUNTER_MUX_SCHED_CONT_EN makes the schedule wrap around until stopped.
module counter_mux_sched
  import counter_pkg::*;
#(
  parameter int COUNTER_NUM = DEF_COUNTER_NUM,
  parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int WIN_W       = DEF_WIN_W
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_start,
  input  logic                           i_stop,
  input  logic [COUNTER_NUM-1:0]         i_chan_en,
  input  logic [WIN_W-1:0]               i_win_len,
  input  logic [COUNTER_NUM-1:0]         i_syn_din,
  output logic [COUNTER_NUM-1:0]         o_mux_sel,
  output logic                           o_busy,
  output logic                           o_res_valid,
  input  logic                           i_res_ready,
  output logic [$clog2(COUNTER_NUM)-1:0] o_res_chan,
  output logic                           o_res_src,
  output logic [CNT_W-1:0]               o_res_cnt,
  output logic                           o_res_ovf
);

  localparam int CH_W  = $clog2(COUNTER_NUM);
  localparam int TMR_W = max_int(WIN_W, $clog2(SETTLE_CYC + 1));
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

  sched_state_t           state, state_n;
  logic [CH_W-1:0]        ch, ch_n;
  logic                   src, src_n;
  logic [COUNTER_NUM-1:0] en_q, en_n;
  logic [WIN_W-1:0]       win_q, win_n;
  logic [TMR_W-1:0]       timer, timer_n;
  logic [TMR_W-1:0]       win_last;
  logic [COUNTER_NUM-1:0] mux_n;
  logic [CH_W-1:0]        start_ch;
  logic [CH_W-1:0]        up_ch;
  logic                   up_found;
`ifdef COUNTER_MUX_SCHED_CONT_EN
  logic [CH_W-1:0]        wrap_ch;
`endif

  // A zero-length window still measures for one cycle
  assign win_last = (win_q == '0) ? '0 : TMR_W'(win_q) - TMR_W'(1);

  always_comb begin
    start_ch = '0;
    for (int i = COUNTER_NUM - 1; i >= 0; i--) begin
      if (i_chan_en[i]) start_ch = CH_W'(i);
    end
  end

  always_comb begin
    up_ch    = '0;
    up_found = 1'b0;
`ifdef COUNTER_MUX_SCHED_CONT_EN
    wrap_ch  = '0;
`endif
    for (int i = COUNTER_NUM - 1; i >= 0; i--) begin
`ifdef COUNTER_MUX_SCHED_CONT_EN
      if (en_q[i]) wrap_ch = CH_W'(i);
`endif
      if (en_q[i] && (i > int'(ch))) begin
        up_found = 1'b1;
        up_ch    = CH_W'(i);
      end
    end
  end

  always_comb begin
    state_n = state;
    ch_n    = ch;
    src_n   = src;
    en_n    = en_q;
    win_n   = win_q;
    timer_n = timer;
    mux_n   = o_mux_sel;
    case (state)
      ST_IDLE: begin
        if (i_start && (i_chan_en != '0)) begin
          state_n = ST_SETTLE;
          en_n    = i_chan_en;
          win_n   = i_win_len;
          ch_n    = start_ch;
          src_n   = 1'b0;
          timer_n = '0;
        end
      end
      ST_SETTLE: begin
        if (timer >= SETTLE_LAST) begin
          state_n = ST_MEASURE;
          timer_n = '0;
        end else begin
          timer_n = timer + TMR_W'(1);
        end
      end
      ST_MEASURE: begin
        if (timer >= win_last) begin
          state_n = ST_REPORT;
          timer_n = '0;
        end else begin
          timer_n = timer + TMR_W'(1);
        end
      end
      ST_REPORT: begin
        if (i_res_ready) begin
          if (!src) begin
            state_n   = ST_SETTLE;
            src_n     = 1'b1;
            mux_n[ch] = 1'b1;
            timer_n   = '0;
          end else begin
            // dropped on the way in so the select is already low during NEXT
            state_n   = ST_NEXT;
            mux_n[ch] = 1'b0;
          end
        end
      end
      ST_NEXT: begin
        timer_n = '0;
        src_n   = 1'b0;
        if (up_found) begin
          state_n = ST_SETTLE;
          ch_n    = up_ch;
        end else begin
`ifdef COUNTER_MUX_SCHED_CONT_EN
          state_n = ST_SETTLE;
          ch_n    = wrap_ch;
`else
          state_n = ST_IDLE;
`endif
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (i_stop && (state != ST_IDLE)) begin
      state_n = ST_IDLE;
      mux_n   = '0;
      src_n   = 1'b0;
      timer_n = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      ch          <= '0;
      src         <= 1'b0;
      en_q        <= '0;
      win_q       <= '0;
      timer       <= '0;
      o_mux_sel   <= '0;
      o_busy      <= 1'b0;
      o_res_valid <= 1'b0;
    end else begin
      state       <= state_n;
      ch          <= ch_n;
      src         <= src_n;
      en_q        <= en_n;
      win_q       <= win_n;
      timer       <= timer_n;
      o_mux_sel   <= mux_n;
      o_busy      <= (state_n != ST_IDLE);
      o_res_valid <= (state_n == ST_REPORT);
    end
  end

  assign o_res_chan = ch;
  assign o_res_src  = src;

  // One counter shared by all channels; SETTLE clears it, REPORT holds the result
  counter_mux_sched_edge #(
    .CNT_W(CNT_W)
  ) u_edge (
    .clk (i_clk),
    .rst (i_rst),
    .clr (state == ST_SETTLE),
    .en  (state == ST_MEASURE),
    .din (i_syn_din[ch]),
    .cnt (o_res_cnt),
    .ovf (o_res_ovf)
  );

endmodule
